// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit hex driver for a common-anode 7-segment display.
// A per-frame snapshot of the inputs keeps each frame free of tearing.
module seg7_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        mclk,
    input  logic        clr,
    input  logic [31:0] data,
    input  logic [7:0]  dp_mask,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   data_snap_q, data_snap_d;
    logic [7:0]    dp_snap_q, dp_snap_d;
    logic          lz_snap_q, lz_snap_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;

    logic          tick, wrap, blank;
    logic [31:0]   src_data;
    logic [7:0]    src_mask;
    logic [3:0]    nib;
    logic [7:0]    zero_from;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // zero_from[k]: snapshot nibbles k..7 are all zero
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_zero
            assign zero_from[gi] = (data_snap_q[31:4*gi] == '0);
        end
    endgenerate

    always_comb begin
        tick         = (presc_q == PRESC_MAX);
        wrap         = tick && (idx_q == 3'd7);
        presc_d      = tick ? '0 : presc_q + 1'b1;
        idx_d        = tick ? idx_q + 3'd1 : idx_q;
        data_snap_d  = data_snap_q;
        dp_snap_d    = dp_snap_q;
        lz_snap_d    = lz_snap_q;
        an_d         = an_q;
        seg_d        = seg_q;
        dp_d         = dp_q;
        frame_done_d = wrap;
        src_data     = wrap ? data : data_snap_q;
        src_mask     = wrap ? dp_mask : dp_snap_q;
        nib          = src_data[{idx_d, 2'b00} +: 4];
        // Digit 0 only ever appears on a wrap and is never blanked
        blank        = !wrap && lz_snap_q && zero_from[idx_d];

        if (wrap) begin
            data_snap_d = data;
            dp_snap_d   = dp_mask;
            lz_snap_d   = blank_lz;
        end

        if (tick) begin
            if (blank) begin
                an_d  = 8'hFF;
                seg_d = 7'h7F;
                dp_d  = 1'b1;
            end else begin
                an_d  = ~(8'b1 << idx_d);
                seg_d = hex_to_seg(nib);
                dp_d  = ~src_mask[idx_d];
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (!clr) begin
            presc_q      <= '0;
            idx_q        <= 3'd7;
            data_snap_q  <= '0;
            dp_snap_q    <= '0;
            lz_snap_q    <= 1'b0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            data_snap_q  <= data_snap_d;
            dp_snap_q    <= dp_snap_d;
            lz_snap_q    <= lz_snap_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed + randomized bench for seg7_scan; expectations come from a
// cycle-count model of the scan schedule and per-frame snapshot.
module tb_seg7_scan;

    localparam int D = 4;

    logic        mclk = 1'b0;
    logic        clr;
    logic [31:0] data;
    logic [7:0]  dp_mask;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    seg7_scan #(.SCAN_DIV(D)) dut (
        .mclk(mclk), .clr(clr), .data(data), .dp_mask(dp_mask),
        .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp),
        .frame_done(frame_done)
    );

    always #5 mclk = ~mclk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_checks = 0;
    int n_pass   = 0;

    // model: k = clock edges seen since reset was released
    int          k = 0;
    logic [31:0] s_data = '0;
    logic [7:0]  s_mask = '0;
    logic        s_lz   = 1'b0;
    int          cur_digit = -1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h (k=%0d)", tag, obs, exp, k);
    endtask

    task automatic cycle();
        int s, d;
        logic blanked;
        logic [3:0] nb;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic e_dp, e_fd;
        @(posedge mclk);
        if (!clr) begin
            k = 0; s_data = '0; s_mask = '0; s_lz = 1'b0;
        end else begin
            k++;
            if (k % D == 0 && ((k / D) - 1) % 8 == 0) begin
                s_data = data; s_mask = dp_mask; s_lz = blank_lz;
            end
        end
        @(negedge mclk);
        s = k / D;
        if (s == 0) begin
            cur_digit = -1;
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            d = (s - 1) % 8;
            cur_digit = d;
            nb = 4'((s_data >> (4 * d)) & 32'hF);
            blanked = s_lz && (d >= 1) && ((s_data >> (4 * d)) == 0);
            e_an  = blanked ? 8'hFF : ~(8'h01 << d);
            e_seg = blanked ? 7'h7F : seg_tab[nb];
            e_dp  = blanked ? 1'b1 : ~s_mask[d];
            e_fd  = (k % D == 0) && (d == 0);
        end
        chk("an", an, e_an);
        chk("seg", {1'b0, seg}, {1'b0, e_seg});
        chk("dp", {7'b0, dp}, {7'b0, e_dp});
        chk("frame_done", {7'b0, frame_done}, {7'b0, e_fd});
        $display("k=%0d clr=%0b data=%h an=%h seg=%h dp=%0b fd=%0b", k, clr, data, an, seg, dp, frame_done);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to_digit(input int dg);
        for (int i = 0; i < 8 * D + 2 && !(cur_digit == dg && k % D == 0); i++) cycle();
        n_checks++;
        assert (cur_digit == dg) n_pass++;
        else $error("FAIL reach_digit: got %0d expected %0d", cur_digit, dg);
    endtask

    initial begin
        clr = 1'b0; data = 32'h89ABCDEF; dp_mask = 8'h00; blank_lz = 1'b0;
        // reset and first frame
        run(3);
        clr = 1'b1;
        run(3);
        cycle();
        chk("first_tick_an", an, 8'hFE);
        chk("first_tick_fd", {7'b0, frame_done}, 8'h01);
        run(8 * D * 2);

        // leading-zero blanking
        data = 32'h0000_00A0; blank_lz = 1'b1;
        run(8 * D * 2);
        data = 32'h0;
        run(8 * D * 2);

        // mid-frame data change stays invisible until next wrap
        data = 32'h12345678; blank_lz = 1'b0;
        run(8 * D);
        run_to_digit(3);
        data = 32'hFFFFFFFF;
        run(8 * D * 2);

        // decimal points
        data = 32'h89ABCDEF; dp_mask = 8'h81;
        run(8 * D * 2);

        // reset mid-scan
        run_to_digit(5);
        clr = 1'b0;
        cycle();
        chk("midreset_an", an, 8'hFF);
        chk("midreset_fd", {7'b0, frame_done}, 8'h00);
        clr = 1'b1;
        run(8 * D * 2);

        // randomized inputs with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                data     = $urandom >> $urandom_range(0, 32);
                dp_mask  = 8'($urandom);
                blank_lz = 1'($urandom);
            end
            clr = ($urandom_range(0, 199) != 0);
            cycle();
        end
        clr = 1'b1;
        run(8 * D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
